// File: rtl/alu_result_if.sv
// Handshake bundle between the adder/subtractor datapath, the result stage
// and its downstream consumer.
interface alu_result_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic             in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [WIDTH-1:0] in_q;
    logic             in_cb;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_q;
    logic             out_zero;
    logic             out_neg;
    logic             out_cb;
    logic             out_ovf;

    modport master (
        output in_valid, in_op, in_a, in_b, in_q, in_cb, out_ready,
        input  in_ready, out_valid, out_q, out_zero, out_neg, out_cb, out_ovf
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_q, in_cb, out_ready,
        output in_ready, out_valid, out_q, out_zero, out_neg, out_cb, out_ovf
    );
endinterface

// File: rtl/alu_result_stage.sv
// Registered result stage: derives status flags from the raw adder/subtractor
// result and buffers them in a small FIFO, with a saturating overflow counter.
module alu_result_stage #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    alu_result_if.slave              bus,
    output logic [7:0]               ovf_count,
    output logic [$clog2(DEPTH):0]   occupancy
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam int ENT_W = WIDTH + 4;
    localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(DEPTH);

    // Signed overflow depends only on operand and result sign bits.
    function automatic logic calc_ovf(input logic op, input logic a_s,
                                      input logic b_s, input logic q_s);
        logic same_sign;
        same_sign = (a_s == b_s);
        calc_ovf  = (op ? !same_sign : same_sign) && (q_s != a_s);
    endfunction

    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [ENT_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             push_s;
    logic             pop_s;
    logic             ovf_s;
    logic [ENT_W-1:0] entry_s;
    logic [ENT_W-1:0] head_s;

    // Next-state decode for FIFO pointers, storage and the overflow counter.
    always_comb begin
        ovf_s   = calc_ovf(bus.in_op, bus.in_a[WIDTH-1], bus.in_b[WIDTH-1],
                           bus.in_q[WIDTH-1]);
        entry_s = {bus.in_q, (bus.in_q == '0), bus.in_q[WIDTH-1], bus.in_cb, ovf_s};
        // rst_n gating keeps the stage closed during the reset cycle itself.
        bus.in_ready  = rst_n && (occ_q < DEPTH_C);
        bus.out_valid = (occ_q != '0);
        push_s = bus.in_valid && bus.in_ready;
        pop_s  = bus.out_valid && bus.out_ready;

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_s) begin
            mem_d[wr_ptr_q] = entry_s;
            wr_ptr_d        = wr_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   occ_d = occ_q + {{(OCC_W-1){1'b0}}, 1'b1};
            2'b01:   occ_d = occ_q - {{(OCC_W-1){1'b0}}, 1'b1};
            default: occ_d = occ_q;
        endcase

        if (push_s && ovf_s && (cnt_q != 8'd255)) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            cnt_q    <= 8'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            cnt_q    <= cnt_d;
        end
    end

    // Head entry presentation, forced to zero while the FIFO is empty.
    always_comb begin
        if (occ_q != '0) begin
            head_s = mem_q[rd_ptr_q];
        end else begin
            head_s = '0;
        end
        {bus.out_q, bus.out_zero, bus.out_neg, bus.out_cb, bus.out_ovf} = head_s;
        ovf_count = cnt_q;
        occupancy = occ_q;
    end
endmodule

// File: tb/tb_alu_result_stage.sv
// Directed, table-driven bench for alu_result_stage (WIDTH=4, DEPTH=2).
module tb_alu_result_stage;
    logic       clk;
    logic       rst_n;
    logic [7:0] ovf_count;
    logic [1:0] occupancy;
    int         checks;
    int         errors;

    alu_result_if #(.WIDTH(4)) bus_if ();

    alu_result_stage #(.WIDTH(4), .DEPTH(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus_if.slave),
        .ovf_count (ovf_count),
        .occupancy (occupancy)
    );

    typedef struct {
        logic       op;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] q;
        logic       cb;
        logic       e_zero;
        logic       e_neg;
        logic       e_ovf;
        logic [7:0] e_cnt;
    } vec_t;

    vec_t vecs [8];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic op, input logic [3:0] a,
                         input logic [3:0] b, input logic [3:0] q, input logic cb);
        bus_if.in_valid = v;
        bus_if.in_op    = op;
        bus_if.in_a     = a;
        bus_if.in_b     = b;
        bus_if.in_q     = q;
        bus_if.in_cb    = cb;
    endtask

    task automatic check_head(input string name, input logic [3:0] q, input logic z,
                              input logic n, input logic cb, input logic o);
        check({name, " valid"}, 32'(bus_if.out_valid), 32'd1);
        check({name, " q"},     32'(bus_if.out_q),     32'(q));
        check({name, " flags"},
              32'({bus_if.out_zero, bus_if.out_neg, bus_if.out_cb, bus_if.out_ovf}),
              32'({z, n, cb, o}));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        //           op    a        b        q        cb    z     n     ovf   cnt
        vecs[0] = '{1'b1, 4'b0101, 4'b0011, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[1] = '{1'b1, 4'b0011, 4'b0101, 4'b1110, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0};
        vecs[2] = '{1'b1, 4'b1000, 4'b0001, 4'b0111, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1};
        vecs[3] = '{1'b0, 4'b0111, 4'b0001, 4'b1000, 1'b0, 1'b0, 1'b1, 1'b1, 8'd2};
        vecs[4] = '{1'b0, 4'b1000, 4'b1000, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1, 8'd3};
        vecs[5] = '{1'b0, 4'b0011, 4'b0100, 4'b0111, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3};
        vecs[6] = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 8'd3};
        vecs[7] = '{1'b0, 4'b0001, 4'b0001, 4'b1111, 1'b1, 1'b0, 1'b1, 1'b1, 8'd4};

        rst_n = 1'b0;
        bus_if.out_ready = 1'b1;
        drive(1'b1, 1'b0, 4'b0111, 4'b0001, 4'b1000, 1'b0);
        tick();
        check("in_ready during reset", 32'(bus_if.in_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
        #1;
        check("reset out_valid", 32'(bus_if.out_valid), 32'd0);
        check("reset in_ready", 32'(bus_if.in_ready), 32'd1);
        check("reset occupancy", 32'(occupancy), 32'd0);
        check("reset ovf_count", 32'(ovf_count), 32'd0);
        check("reset out fields",
              32'({bus_if.out_q, bus_if.out_zero, bus_if.out_neg, bus_if.out_cb, bus_if.out_ovf}),
              32'd0);

        // Flag table: one accepted result per cycle, popped the following cycle.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].cb);
            tick();
            check_head($sformatf("vec%0d", i), vecs[i].q, vecs[i].e_zero,
                       vecs[i].e_neg, vecs[i].cb, vecs[i].e_ovf);
            check($sformatf("vec%0d ovf_count", i), 32'(ovf_count), 32'(vecs[i].e_cnt));
            check($sformatf("vec%0d occupancy", i), 32'(occupancy), 32'd1);
        end
        drive(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
        tick();
        check("table drained", 32'(occupancy), 32'd0);

        // Backpressure: A and B fill the FIFO, C must wait for a free slot.
        bus_if.out_ready = 1'b0;
        drive(1'b1, 1'b0, 4'b0001, 4'b0001, 4'b0010, 1'b0);
        tick();
        check("bp occ after A", 32'(occupancy), 32'd1);
        check("bp in_ready after A", 32'(bus_if.in_ready), 32'd1);
        drive(1'b1, 1'b0, 4'b0010, 4'b0010, 4'b0100, 1'b0);
        tick();
        check("bp occ after B", 32'(occupancy), 32'd2);
        check("bp in_ready after B", 32'(bus_if.in_ready), 32'd0);
        drive(1'b1, 1'b0, 4'b0111, 4'b0001, 4'b1000, 1'b0);
        tick();
        check("bp C refused occ", 32'(occupancy), 32'd2);
        check_head("bp head stable A", 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0);
        check("bp C refused cnt", 32'(ovf_count), 32'd4);
        bus_if.out_ready = 1'b1;
        tick();
        check("bp pop while full occ", 32'(occupancy), 32'd1);
        check_head("bp head B", 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
        check("bp C accepted occ", 32'(occupancy), 32'd1);
        check_head("bp head C", 4'b1000, 1'b0, 1'b1, 1'b0, 1'b1);
        check("bp C cnt", 32'(ovf_count), 32'd5);
        tick();
        check("bp drained", 32'(bus_if.out_valid), 32'd0);

        // Streaming: ten back-to-back results through a two-entry FIFO.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0, 4'(i), 4'd0, 4'(i), 1'b0);
            tick();
            check_head($sformatf("stream%0d", i), 4'(i), (i == 0), 1'(i >> 3), 1'b0, 1'b0);
            check($sformatf("stream%0d occ", i), 32'(occupancy), 32'd1);
        end
        drive(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
        tick();
        check("stream drained", 32'(occupancy), 32'd0);

        // Mid-stream reset with a full FIFO and a non-zero overflow count.
        bus_if.out_ready = 1'b0;
        drive(1'b1, 1'b0, 4'b0001, 4'b0001, 4'b0010, 1'b0);
        tick();
        tick();
        check("pre-reset occ", 32'(occupancy), 32'd2);
        check("pre-reset cnt", 32'(ovf_count), 32'd5);
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 4'b0111, 4'b0001, 4'b1000, 1'b0);
        bus_if.out_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
        #1;
        check("midreset out_valid", 32'(bus_if.out_valid), 32'd0);
        check("midreset occ", 32'(occupancy), 32'd0);
        check("midreset cnt", 32'(ovf_count), 32'd0);
        check("midreset in_ready", 32'(bus_if.in_ready), 32'd1);
        check("midreset out_q", 32'(bus_if.out_q), 32'd0);

        // Overflow counter saturation.
        for (int i = 1; i <= 300; i++) begin
            drive(1'b1, 1'b0, 4'b0111, 4'b0001, 4'b1000, 1'b0);
            tick();
            if (i == 200) check("sat cnt 200", 32'(ovf_count), 32'd200);
            if (i == 255) check("sat cnt 255", 32'(ovf_count), 32'd255);
        end
        drive(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
        tick();
        check("sat cnt 300", 32'(ovf_count), 32'd255);
        check("sat drained", 32'(occupancy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_result_stage.md
# alu_result_stage

Registered output stage placed directly downstream of the 4-bit ripple adder/ripple-borrow subtractor datapath. It captures each raw result (`q` plus carry/borrow-out) together with the operands and operation that produced it. It derives status flags (zero, negative, carry/borrow, signed overflow) and buffers results in a small FIFO behind a valid/ready handshake. It also keeps a saturating count of signed-overflow results for debug visibility.

## Interface
Parameters:
- `WIDTH`, 4: datapath width in bits.
- `DEPTH`, 2: result FIFO entries; must be a power of two, 2 or greater.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: synchronous, active-low reset.
- `in_valid`, input, 1: upstream result valid.
- `in_ready`, output, 1: stage can accept a result this cycle.
- `in_op`, input, 1: operation that produced the result; 0 = add, 1 = subtract (a − b).
- `in_a`, input, `WIDTH`: operand a fed to the arithmetic unit.
- `in_b`, input, `WIDTH`: operand b fed to the arithmetic unit.
- `in_q`, input, `WIDTH`: raw sum/difference from the arithmetic unit.
- `in_cb`, input, 1: carry-out (add) or borrow-out (subtract).
- `out_valid`, output, 1: head entry valid.
- `out_ready`, input, 1: downstream accepts the head entry.
- `out_q`, output, `WIDTH`: buffered result.
- `out_zero`, output, 1: flag, result == 0.
- `out_neg`, output, 1: flag, result MSB.
- `out_cb`, output, 1: buffered carry/borrow.
- `out_ovf`, output, 1: flag, signed two's-complement overflow.
- `ovf_count`, output, 8: saturating count of accepted results with overflow.
- `occupancy`, output, clog2(`DEPTH`)+1: number of entries held.

## Operation
- Accept when `in_valid && in_ready`. Flags are computed combinationally from the inputs and written into the FIFO with `in_q` and `in_cb`.
- Flag rules (s = bit `WIDTH`−1):
  - zero = (`in_q` == 0).
  - neg = `in_q`[s].
  - cb = `in_cb`, passed through unmodified. No inversion: borrow = 1 means a < b unsigned.
  - ovf for add: `in_a`[s] == `in_b`[s] and `in_q`[s] != `in_a`[s].
  - ovf for subtract: `in_a`[s] != `in_b`[s] and `in_q`[s] != `in_a`[s].
- The stage never recomputes `in_q`. An inconsistent `in_q` is stored as given, and flags are derived from it.
- FIFO: circular buffer with write pointer, read pointer and occupancy counter. Pointers wrap modulo `DEPTH`.
- `in_ready` = (occupancy < `DEPTH`). It is decoded from registered state only, with no combinational path from `out_ready`.
- Pop when `out_valid && out_ready`. `out_*` always present the head entry. Their values are don't-care when `out_valid` = 0, but are driven to 0 for determinism.
- Simultaneous push and pop while not full: occupancy unchanged, both pointers advance.
- When full, push is refused even if a pop occurs in the same cycle. A push can succeed the cycle after the pop.
- Simultaneous push and pop while empty: pop is not possible (`out_valid` = 0). The push lands and occupancy becomes 1.
- `ovf_count` increments on each accepted entry with ovf = 1. It saturates at 255, and only reset clears it.
- Reset, including mid-stream: all entries discarded; pointers, occupancy and `ovf_count` = 0; `out_valid` = 0; `in_ready` = 0 during the reset cycle and 1 on the first cycle after `rst_n` returns high. `out_q`, `out_zero`, `out_neg`, `out_cb` and `out_ovf` = 0. Inputs presented during reset are ignored.

## Timing
- Latency: an entry accepted at edge N is visible with `out_valid` = 1 after edge N (the cycle after acceptance). There is no combinational input-to-output path.
- Throughput: 1 result/cycle sustained while `out_ready` = 1 and `DEPTH` ≥ 2.
- `out_valid`, `out_q` and the flags remain stable while `out_valid && !out_ready`.
- `occupancy` and `ovf_count` reflect the state after the most recent edge.

## Test plan
- Subtract a=0101, b=0011, q=0010, cb=0 → one cycle later `out_q`=0010, zero=0, neg=0, cb=0, ovf=0.
- Subtract a=0011, b=0101, q=1110, cb=1 → neg=1, cb=1, ovf=0. Subtract a=1000, b=0001, q=0111, cb=0 → ovf=1, `ovf_count`=1.
- Add a=0111, b=0001, q=1000, cb=0 → neg=1, ovf=1. Add a=1000, b=1000, q=0000, cb=1 → zero=1, cb=1, ovf=1.
- Backpressure: hold `out_ready`=0 and push 3 results → `in_ready`=0 after the 2nd, occupancy=2, 3rd not accepted. Release `out_ready` → results drain in order, then the 3rd is accepted.
- Streaming: `out_ready`=1 with 10 back-to-back pushes → 10 outputs in order, one per cycle; occupancy stays ≤ 1; pointer wrap exercised.
- Reset mid-stream with occupancy=2 and `ovf_count`=5 → next cycle `out_valid`=0, occupancy=0, `ovf_count`=0, `in_ready`=1. Separately, 300 overflow pushes → `ovf_count`=255.
